// File: rtl/config_router.sv
// Address-range config write router: decodes one host write stream onto NUM_CONFIGS
// rebased ports (plus optional broadcast window) through a fixed-latency pipeline.

module config_router_lane #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vld,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_vld,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_data
);
  logic [PIPE_STAGES:1]                r_vld_pipe;
  logic [PIPE_STAGES:1][ADDR_BITS-1:0] r_addr_pipe;
  logic [PIPE_STAGES:1][DATA_BITS-1:0] r_data_pipe;

  // Payload registers only load behind a valid so outputs hold their last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_data_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      if (i_vld) begin
        r_addr_pipe[1] <= i_addr;
        r_data_pipe[1] <= i_data;
      end
      for (int s = 2; s <= PIPE_STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) begin
          r_addr_pipe[s] <= r_addr_pipe[s-1];
          r_data_pipe[s] <= r_data_pipe[s-1];
        end
      end
    end
  end

  assign o_vld  = r_vld_pipe[PIPE_STAGES];
  assign o_addr = r_addr_pipe[PIPE_STAGES];
  assign o_data = r_data_pipe[PIPE_STAGES];
endmodule

module config_router #(
  parameter int                                  NUM_CONFIGS  = 4,
  parameter int                                  ADDR_BITS    = 32,
  parameter int                                  DATA_BITS    = 32,
  parameter logic [NUM_CONFIGS:0][ADDR_BITS-1:0] BOUNDS       = {32'd64, 32'd48, 32'd32, 32'd16, 32'd0},
  parameter int                                  PIPE_STAGES  = 1,
  parameter int                                  BCAST_EN     = 0,
  parameter logic [ADDR_BITS-1:0]                BCAST_BASE   = 32'h400,
  parameter int                                  BCAST_SIZE   = 16,
  parameter int                                  ERR_CNT_BITS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [ADDR_BITS-1:0]                  in_addr,
  input  logic [DATA_BITS-1:0]                  in_data,
  output logic [NUM_CONFIGS-1:0]                out_valid,
  output logic [NUM_CONFIGS-1:0][ADDR_BITS-1:0] out_addr,
  output logic [NUM_CONFIGS-1:0][DATA_BITS-1:0] out_data,
  input  logic                                  err_clear,
  output logic                                  err_sticky,
  output logic [ERR_CNT_BITS-1:0]               err_count,
  output logic [ADDR_BITS-1:0]                  err_addr
);
  // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
  localparam int ABW = ADDR_BITS + 1;

  logic                                  w_bcast;
  logic                                  w_found;
  logic                                  w_hit;
  logic                                  w_miss;
  logic [NUM_CONFIGS-1:0]                w_sel;
  logic [NUM_CONFIGS-1:0][ADDR_BITS-1:0] w_raddr;

  always_comb begin
    w_bcast = (BCAST_EN != 0) &&
              ({1'b0, in_addr} >= ABW'(BCAST_BASE)) &&
              ({1'b0, in_addr} <  ABW'(BCAST_BASE) + ABW'(BCAST_SIZE));
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_sel   = '0;
    w_raddr = '0;
    for (int i = 0; i < NUM_CONFIGS; i++) begin
      w_hit      = (in_addr >= BOUNDS[i]) && (in_addr < BOUNDS[i+1]);
      w_sel[i]   = in_valid && (w_bcast || (w_hit && !w_found));
      w_raddr[i] = w_bcast ? (in_addr - BCAST_BASE) : (in_addr - BOUNDS[i]);
      w_found    = w_found | w_hit;
    end
    w_miss = in_valid && !w_bcast && !w_found;
  end

  for (genvar g = 0; g < NUM_CONFIGS; g++) begin : g_lane
    config_router_lane #(
      .ADDR_BITS  (ADDR_BITS),
      .DATA_BITS  (DATA_BITS),
      .PIPE_STAGES(PIPE_STAGES)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (w_sel[g]),
      .i_addr(w_raddr[g]),
      .i_data(in_data),
      .o_vld (out_valid[g]),
      .o_addr(out_addr[g]),
      .o_data(out_data[g])
    );
  end

  logic                    r_err_sticky;
  logic [ERR_CNT_BITS-1:0] r_err_count;
  logic [ADDR_BITS-1:0]    r_err_addr;
  logic                    w_sticky_nxt;
  logic [ERR_CNT_BITS-1:0] w_cnt_nxt;
  logic [ADDR_BITS-1:0]    w_eaddr_nxt;

  // Clear applies first, so a miss in the clear cycle records as the new first miss.
  always_comb begin
    w_sticky_nxt = err_clear ? 1'b0 : r_err_sticky;
    w_cnt_nxt    = err_clear ? '0   : r_err_count;
    w_eaddr_nxt  = err_clear ? '0   : r_err_addr;
    if (w_miss) begin
      w_sticky_nxt = 1'b1;
      if (w_cnt_nxt == '0) w_eaddr_nxt = in_addr;
      if (w_cnt_nxt != '1) w_cnt_nxt = w_cnt_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_err_addr   <= '0;
    end else begin
      r_err_sticky <= w_sticky_nxt;
      r_err_count  <= w_cnt_nxt;
      r_err_addr   <= w_eaddr_nxt;
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign err_addr   = r_err_addr;
endmodule

// File: tb/tb_config_router.sv
// Scoreboard bench for config_router: directed writes push expected port events,
// a negedge monitor pops and compares them; error registers checked directly.

module tb_config_router;
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic [31:0]           in_addr = '0;
  logic [31:0]           in_data = '0;
  logic                  err_clear = 1'b0;
  logic [2:0]            out_valid;
  logic [2:0][31:0]      out_addr;
  logic [2:0][31:0]      out_data;
  logic                  err_sticky;
  logic [15:0]           err_count;
  logic [31:0]           err_addr;

  // Narrow-counter instance used only to reach counter saturation quickly.
  logic                  s_valid = 1'b0;
  logic [3:0]            s_out_valid;
  logic [3:0][31:0]      s_out_addr;
  logic [3:0][31:0]      s_out_data;
  logic                  s_err_sticky;
  logic [1:0]            s_err_count;
  logic [31:0]           s_err_addr;

  config_router #(
    .NUM_CONFIGS(3), .ADDR_BITS(32), .DATA_BITS(32),
    .BOUNDS({32'd256, 32'd64, 32'd16, 32'd0}),
    .PIPE_STAGES(2), .BCAST_EN(1), .BCAST_BASE(32'd1024), .BCAST_SIZE(16),
    .ERR_CNT_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .err_clear(err_clear), .err_sticky(err_sticky), .err_count(err_count), .err_addr(err_addr)
  );

  config_router #(.ERR_CNT_BITS(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_addr(32'h1000), .in_data(32'h0),
    .out_valid(s_out_valid), .out_addr(s_out_addr), .out_data(s_out_data),
    .err_clear(1'b0), .err_sticky(s_err_sticky), .err_count(s_err_count), .err_addr(s_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && |out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_valid", 64'(out_valid), 64'(e.v));
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
        for (int p = 0; p < 3; p++) begin
          if (e.v[p]) begin
            chk($sformatf("out_addr[%0d]", p), 64'(out_addr[p]), 64'(e.a));
            chk($sformatf("out_data[%0d]", p), 64'(out_data[p]), 64'(e.d));
          end
        end
      end
    end
  end

  // v=0 marks a write expected to produce no port output.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] v,
                    input logic [31:0] ra, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; in_data = d; err_clear = clr;
    if (v != 3'b000) begin
      e.v = v; e.a = ra; e.d = d; e.cyc = cyc + 2;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; err_clear = 1'b0;
    end
  endtask

  task automatic chk_err(input string tag, input logic s, input logic [15:0] c, input logic [31:0] a);
    chk({tag, "_sticky"}, 64'(err_sticky), 64'(s));
    chk({tag, "_count"},  64'(err_count),  64'(c));
    chk({tag, "_addr"},   64'(err_addr),   64'(a));
  endtask

  logic [31:0] t2_addr [6] = '{32'd0, 32'd15, 32'd16, 32'd63, 32'd64, 32'd255};
  logic [2:0]  t2_port [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [31:0] t2_reb  [6] = '{32'd0, 32'd15, 32'd0, 32'd47, 32'd0, 32'd191};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr0", 64'(out_addr[0]), 64'd0);
    chk("rst_out_data2", 64'(out_data[2]), 64'd0);
    chk_err("rst", 1'b0, 16'd0, 32'd0);
    rst_n = 1'b1;
    idle(2);

    wr(32'd20, 32'hAB, 3'b010, 32'd4, 1'b0);
    idle(4);

    for (int i = 0; i < 6; i++) wr(t2_addr[i], 32'hA0 + i, t2_port[i], t2_reb[i], 1'b0);
    idle(4);

    wr(32'd1030, 32'h55, 3'b111, 32'd6, 1'b0);
    wr(32'd1039, 32'h66, 3'b111, 32'd15, 1'b0);
    wr(32'd1040, 32'h77, 3'b000, 32'd0, 1'b0);
    idle(1);
    chk_err("bcast_edge_miss", 1'b1, 16'd1, 32'd1040);
    @(negedge clk); err_clear = 1'b1;
    idle(1);
    chk_err("clear_alone", 1'b0, 16'd0, 32'd0);
    idle(3);

    wr(32'd300, 32'h1, 3'b000, 32'd0, 1'b0);
    wr(32'd500, 32'h2, 3'b000, 32'd0, 1'b0);
    idle(1);
    chk_err("two_miss", 1'b1, 16'd2, 32'd300);
    wr(32'd700, 32'h3, 3'b000, 32'd0, 1'b1);
    idle(1);
    chk_err("clear_with_miss", 1'b1, 16'd1, 32'd700);
    idle(3);

    @(negedge clk); s_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("sat_count_2", 64'(s_err_count), 64'd2);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("sat_count_hold", 64'(s_err_count), 64'd3);
    chk("sat_sticky", 64'(s_err_sticky), 64'd1);
    chk("sat_addr", 64'(s_err_addr), 64'h1000);
    chk("sat_no_out", 64'(s_out_valid), 64'd0);

    wr(32'd20, 32'hCD, 3'b000, 32'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_addr1", 64'(out_addr[1]), 64'd0);
    chk("midrst_out_data1", 64'(out_data[1]), 64'd0);
    chk_err("midrst", 1'b0, 16'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
